// File: rtl/router_pkg.sv
// Shared definitions for the Aurora packet encap/decap path.
// Holds the link/DFX width constants, the header field offsets inside the
// 9-bit header, the size of the short final chunk, the decapsulator state
// enum and the stored header struct.
package router_pkg;
  localparam int DATA_WIDTH             = 1024;
  localparam int ADDR_WIDTH             = 10;
  localparam int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH;
  localparam int RECOGNIZE_ROUTER_WIDTH = 2;
  localparam int NUMBER_PACKET          = 19;
  localparam int TTL_WIDTH              = $clog2(3);
  localparam int INDEX_WIDTH            = $clog2(NUMBER_PACKET);
  localparam int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + INDEX_WIDTH + TTL_WIDTH;
  localparam int AURORA_DATA_WIDTH      = 64;
  localparam int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH;

  // Header bit offsets: [8:7] router id, [6:2] chunk index, [1:0] TTL.
  localparam int ROUTER_LSB = 7;
  localparam int INDEX_LSB  = 2;
  localparam int TTL_LSB    = 0;

  // The last chunk only carries what is left of the 1034-bit word.
  localparam int LAST_CHUNK_BITS = 44;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] rid;
    logic [INDEX_WIDTH-1:0]            idx;
    logic [TTL_WIDTH-1:0]              ttl;
  } hdr_t;
endpackage

// File: rtl/decap_packet_if.sv
// Bus bundle between the Aurora RX link, the decapsulator and the DFX
// receive logic.
//   data_out_port_0 / data_out_valid / ready_decap : link word in
//   data_dfx_recv / header_pkt_recv / dfx_recv_valid / dfx_recv_ready : frame out
//   err_index / err_router / err_overflow : one-cycle error pulses
// slave = the decapsulator, master = its environment.
interface decap_packet_if;
  import router_pkg::*;

  logic [AURORA_DATA_WIDTH-1:0] data_out_port_0;
  logic                         data_out_valid;
  logic                         ready_decap;
  logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv;
  logic [HEADER_WIDTH-1:0]      header_pkt_recv;
  logic                         dfx_recv_valid;
  logic                         dfx_recv_ready;
  logic                         err_index;
  logic                         err_router;
  logic                         err_overflow;

  modport slave (
    input  data_out_port_0, data_out_valid, dfx_recv_ready,
    output ready_decap, data_dfx_recv, header_pkt_recv, dfx_recv_valid,
           err_index, err_router, err_overflow
  );

  modport master (
    output data_out_port_0, data_out_valid, dfx_recv_ready,
    input  ready_decap, data_dfx_recv, header_pkt_recv, dfx_recv_valid,
           err_index, err_router, err_overflow
  );
endinterface

// File: rtl/chunk_tracker.sv
// Received-chunk bitmap for one frame.
//   clk, rst_n  : clock, async active-low reset
//   set_i/idx_i : mark chunk idx_i as received
//   clr_i       : clear the whole bitmap (frame handed off)
//   full_nxt_o  : bitmap would be all-ones after this cycle's set
module chunk_tracker
  import router_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_i,
  input  logic [INDEX_WIDTH-1:0] idx_i,
  input  logic                   clr_i,
  output logic                   full_nxt_o
);
  logic [NUMBER_PACKET-1:0] bits_q, bits_d, set_mask;

  always_comb begin
    set_mask = '0;
    for (int k = 0; k < NUMBER_PACKET; k++)
      if (set_i && idx_i == INDEX_WIDTH'(k)) set_mask[k] = 1'b1;
    // A duplicate index ORs into an already-set bit: bitmap unchanged.
    bits_d     = clr_i ? '0 : (bits_q | set_mask);
    full_nxt_o = &(bits_q | set_mask);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bits_q <= '0;
    else        bits_q <= bits_d;
endmodule

// File: rtl/decap_packet.sv
// Reassembles 19 Aurora words (9-bit header + 55-bit chunk) into one
// 1034-bit DFX word and hands it off with its header over valid/ready.
//   clk, rst_n : clock, async active-low reset
//   bus        : decap_packet_if.slave (link in, frame out, error pulses)
module decap_packet
  import router_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  decap_packet_if.slave  bus
);
  state_e                              state_q, state_d;
  logic [DATA_DFX_WIDTH-1:0]           data_q;
  hdr_t                                hdr_q;
  logic [HEADER_WIDTH-1:0]             hdr_w;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0]   rid_w;
  logic [INDEX_WIDTH-1:0]              idx_w;
  logic [TTL_WIDTH-1:0]                ttl_w;
  logic [PAYLOAD_WIDTH-1:0]            pay_w;
  logic accept, idx_ok, rid_ok, store, hshake, full_nxt;
  logic err_index_q, err_index_d;
  logic err_router_q, err_router_d;
  logic err_overflow_q, err_overflow_d;

  assign hdr_w = bus.data_out_port_0[AURORA_DATA_WIDTH-1 -: HEADER_WIDTH];
  assign pay_w = bus.data_out_port_0[PAYLOAD_WIDTH-1:0];
  assign rid_w = hdr_w[ROUTER_LSB +: RECOGNIZE_ROUTER_WIDTH];
  assign idx_w = hdr_w[INDEX_LSB  +: INDEX_WIDTH];
  assign ttl_w = hdr_w[TTL_LSB    +: TTL_WIDTH];

  chunk_tracker u_trk (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (store),
    .idx_i      (idx_w),
    .clr_i      (hshake),
    .full_nxt_o (full_nxt)
  );

  always_comb begin
    state_d        = state_q;
    accept         = bus.data_out_valid && (state_q != ST_DONE);
    idx_ok         = idx_w < INDEX_WIDTH'(NUMBER_PACKET);
    // The first word of a frame defines the router id, so IDLE never mismatches.
    rid_ok         = (state_q == ST_IDLE) || (rid_w == hdr_q.rid);
    store          = accept && idx_ok && rid_ok;
    hshake         = (state_q == ST_DONE) && bus.dfx_recv_ready;
    // Index error has priority over router error.
    err_index_d    = accept && !idx_ok;
    err_router_d   = accept && idx_ok && !rid_ok;
    err_overflow_d = bus.data_out_valid && (state_q == ST_DONE);
    case (state_q)
      ST_IDLE, ST_COLLECT: if (store) state_d = full_nxt ? ST_DONE : ST_COLLECT;
      ST_DONE:             if (hshake) state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      hdr_q          <= '0;
      err_index_q    <= 1'b0;
      err_router_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      err_index_q    <= err_index_d;
      err_router_q   <= err_router_d;
      err_overflow_q <= err_overflow_d;
      // TTL follows the latest accepted word; index field is fixed to last chunk.
      if (store) hdr_q <= '{rid: rid_w, idx: INDEX_WIDTH'(NUMBER_PACKET-1), ttl: ttl_w};
    end

  // Data register is not cleared on handshake; each new frame overwrites it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_q <= '0;
    else if (store) begin
      for (int k = 0; k < NUMBER_PACKET-1; k++)
        if (idx_w == INDEX_WIDTH'(k)) data_q[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= pay_w;
      if (idx_w == INDEX_WIDTH'(NUMBER_PACKET-1))
        data_q[DATA_DFX_WIDTH-1 -: LAST_CHUNK_BITS] <= pay_w[LAST_CHUNK_BITS-1:0];
    end

  assign bus.ready_decap     = (state_q != ST_DONE);
  assign bus.dfx_recv_valid  = (state_q == ST_DONE);
  assign bus.data_dfx_recv   = data_q;
  assign bus.header_pkt_recv = hdr_q;
  assign bus.err_index       = err_index_q;
  assign bus.err_router      = err_router_q;
  assign bus.err_overflow    = err_overflow_q;
endmodule
